// File: rtl/beep_pattern_gen.sv
// Buzzer driver: square tone (programmable period/duty) gated into on/off bursts,
// fixed-count or continuous. Define BEEP_ACTIVE_LOW_EN to invert the beep pin.
module beep_pattern_gen #(
    parameter int DIV_W  = 20,
    parameter int GATE_W = 25,
    parameter int REP_W  = 8
) (
    input  logic              ext_clk_25m,
    input  logic              ext_rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  period,
    input  logic [7:0]        duty,
    input  logic [GATE_W-1:0] on_time,
    input  logic [GATE_W-1:0] off_time,
    input  logic [REP_W-1:0]  reps,
    output logic              beep,
    output logic              busy,
    output logic              done
);

`ifdef BEEP_ACTIVE_LOW_EN
    localparam logic BEEP_IDLE = 1'b1;
`else
    localparam logic BEEP_IDLE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ON, S_OFF} state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  period_r, high_cnt, tcnt;
    logic [7:0]        duty_r;
    logic [GATE_W-1:0] on_time_r, off_time_r, gcnt;
    logic [REP_W-1:0]  reps_r, rcnt;
    logic [DIV_W+7:0]  product;
    logic              accept, gate_last_on, gate_last_off, last_burst, burst_end, done_next;

    assign product       = {8'd0, period_r} * {{DIV_W{1'b0}}, duty_r};
    assign accept        = (state == S_IDLE) && start && !stop;
    assign gate_last_on  = (gcnt == on_time_r - GATE_W'(1));
    assign gate_last_off = (gcnt == off_time_r - GATE_W'(1));
    assign last_burst    = (reps_r != '0) && ((rcnt + REP_W'(1)) == reps_r);
    assign burst_end     = ((state == S_ON) && gate_last_on && (off_time_r == '0))
                        || ((state == S_OFF) && gate_last_off);
    assign done_next     = burst_end && last_burst && !stop;

    always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
        if (ext_rst) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_LOAD;
            S_LOAD: state_next = S_ON;
            S_ON: begin
                if (gate_last_on) begin
                    if (off_time_r != '0) state_next = S_OFF;
                    else if (last_burst)  state_next = S_IDLE;
                end
            end
            S_OFF: begin
                if (gate_last_off) state_next = last_burst ? S_IDLE : S_ON;
            end
            default: state_next = S_IDLE;
        endcase
        if (stop && (state != S_IDLE)) state_next = S_IDLE;
    end

    always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
        if (ext_rst) begin
            period_r   <= '0;
            duty_r     <= '0;
            on_time_r  <= '0;
            off_time_r <= '0;
            reps_r     <= '0;
            high_cnt   <= '0;
            tcnt       <= '0;
            gcnt       <= '0;
            rcnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    gcnt <= '0;
                    rcnt <= '0;
                    if (accept) begin
                        period_r   <= (period < DIV_W'(2)) ? DIV_W'(2) : period;
                        duty_r     <= duty;
                        on_time_r  <= (on_time == '0) ? GATE_W'(1) : on_time;
                        off_time_r <= off_time;
                        reps_r     <= reps;
                    end
                end
                S_LOAD: begin
                    high_cnt <= DIV_W'(product >> 8);
                    tcnt     <= '0;
                    gcnt     <= '0;
                    rcnt     <= '0;
                end
                S_ON: begin
                    tcnt <= (tcnt == period_r - DIV_W'(1)) ? '0 : tcnt + DIV_W'(1);
                    gcnt <= gate_last_on ? '0 : gcnt + GATE_W'(1);
                end
                S_OFF: begin
                    gcnt <= gate_last_off ? '0 : gcnt + GATE_W'(1);
                end
                default: ;
            endcase
            // Every burst restarts the tone on a rising edge; rcnt saturates so
            // continuous mode can never wrap into a false completion.
            if (burst_end) begin
                tcnt <= '0;
                rcnt <= (rcnt == '1) ? rcnt : rcnt + REP_W'(1);
            end
        end
    end

    always_ff @(posedge ext_clk_25m or posedge ext_rst) begin
        if (ext_rst) begin
            beep <= BEEP_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= done_next;
            if ((state == S_ON) && (state_next != S_IDLE))
                beep <= BEEP_IDLE ^ (tcnt < high_cnt);
            else
                beep <= BEEP_IDLE;
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed bench for beep_pattern_gen with hand-computed expectations.
// Define BEEP_ACTIVE_LOW_EN for both RTL and bench to check the inverted pin.
module tb_beep_pattern_gen;
    localparam int DIV_W  = 20;
    localparam int GATE_W = 25;
    localparam int REP_W  = 8;
`ifdef BEEP_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              ext_rst, start, stop;
    logic [DIV_W-1:0]  period;
    logic [7:0]        duty;
    logic [GATE_W-1:0] on_time, off_time;
    logic [REP_W-1:0]  reps;
    logic              beep, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    always #20 clk = ~clk;

    beep_pattern_gen #(.DIV_W(DIV_W), .GATE_W(GATE_W), .REP_W(REP_W)) dut (
        .ext_clk_25m(clk), .ext_rst(ext_rst), .start(start), .stop(stop),
        .period(period), .duty(duty), .on_time(on_time), .off_time(off_time),
        .reps(reps), .beep(beep), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start so that it is sampled on the next edge (edge k); returns just after edge k.
    task automatic do_start(input int p, input int d, input int on, input int off, input int r);
        period   = DIV_W'(p);
        duty     = 8'(d);
        on_time  = GATE_W'(on);
        off_time = GATE_W'(off);
        reps     = REP_W'(r);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Active-high tone level seen after edge k+1+m (m >= 1).
    function automatic logic tone_exp(input int m, input int per, input int hi,
                                      input int on, input int burst);
        int pos;
        pos = (m - 1) % burst;
        return (pos < on) && ((pos % per) < hi);
    endfunction

    initial begin
        int cnt_a, cnt_b;
        ext_rst = 1'b1; start = 1'b0; stop = 1'b0;
        period = '0; duty = '0; on_time = '0; off_time = '0; reps = '0;
        #5;
        check("rst_beep", beep, INV);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step(); step();
        ext_rst = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // Tone shape: 5 high / 5 low, 40 on, 20 off, 3 bursts, done after k+181.
        do_start(10, 128, 40, 20, 3);
        check("tone_busy_k", busy, 1);
        step();
        check("tone_beep_k1", beep, INV);
        for (int m = 1; m <= 179; m++) begin
            step();
            check("tone_beep", beep, tone_exp(m, 10, 5, 40, 60) ^ INV);
        end
        check("tone_done_k180", done, 0);
        check("tone_busy_k180", busy, 1);
        step();
        check("tone_done_k181", done, 1);
        check("tone_busy_k181", busy, 0);
        check("tone_beep_k181", beep, INV);
        step();
        check("tone_done_clear", done, 0);

        // Clamping: period 2, one-clock bursts, done after k+3.
        do_start(1, 128, 0, 0, 2);
        step();
        check("clamp_beep_k1", beep, INV);
        step();
        check("clamp_beep_k2", beep, 1'b1 ^ INV);
        check("clamp_done_k2", done, 0);
        step();
        check("clamp_done_k3", done, 1);
        check("clamp_busy_k3", busy, 0);
        check("clamp_beep_k3", beep, INV);
        step();

        // Silence: duty 0, 2 bursts of 5+3, done after k+17.
        do_start(10, 0, 5, 3, 2);
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (beep !== INV) cnt_a++;
            if (busy !== 1'b1) cnt_b++;
        end
        check("silence_beep_active", cnt_a, 0);
        check("silence_busy_low", cnt_b, 0);
        step();
        check("silence_done", done, 1);
        step();

        // Full duty: period 256, duty 255 -> 255 high / 1 low.
        do_start(256, 255, 512, 0, 1);
        step();
        for (int m = 1; m <= 511; m++) begin
            step();
            check("full_beep", beep, tone_exp(m, 256, 255, 512, 512) ^ INV);
        end
        step();
        check("full_done", done, 1);
        check("full_busy", busy, 0);
        step();

        // Infinite bursts (22 clocks each, >300 bursts), then stop mid-ON.
        do_start(4, 128, 20, 2, 0);
        step();
        cnt_a = 0; cnt_b = 0;
        for (int m = 1; m <= 6601; m++) begin
            step();
            if (done !== 1'b0) cnt_a++;
            if (busy !== 1'b1) cnt_b++;
        end
        check("inf_done_pulses", cnt_a, 0);
        check("inf_busy_low", cnt_b, 0);
        check("inf_beep_pre_stop", beep, 1'b1 ^ INV);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_beep", beep, INV);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        step();
        check("stop_done_next", done, 0);

        // Start while busy and input changes after the latch are ignored.
        do_start(4, 128, 4, 4, 2);
        step(); step(); step();
        do_start(2, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) step();
        check("hs_beep_k11", beep, 1'b1 ^ INV);
        for (int i = 0; i < 5; i++) step();
        check("hs_done_k16", done, 0);
        check("hs_busy_k16", busy, 1);
        step();
        check("hs_done_k17", done, 1);
        step();
        check("hs_busy_after", busy, 0);

        // start and stop together from IDLE: stop wins.
        period = 20'd10; duty = 8'd128; on_time = 25'd4; off_time = 25'd4; reps = 8'd1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 0);
        step();
        check("ss_busy_next", busy, 0);
        check("ss_beep", beep, INV);

        // Reset in the second burst's OFF phase, then a full new sequence.
        do_start(4, 128, 4, 4, 2);
        for (int i = 0; i < 14; i++) step();
        check("mr_busy_pre", busy, 1);
        ext_rst = 1'b1;
        #2;
        check("mr_beep", beep, INV);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        step();
        ext_rst = 1'b0;
        step();
        check("mr_busy_released", busy, 0);
        do_start(4, 128, 4, 4, 2);
        for (int i = 0; i < 16; i++) step();
        check("mr_done_k16", done, 0);
        check("mr_busy_k16", busy, 1);
        step();
        check("mr_done_k17", done, 1);
        check("mr_busy_k17", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/beep_pattern_gen.md
# beep_pattern_gen

Parametrised buzzer driver for the traffic-light controller: generates a square tone with programmable period and duty cycle, gated into repeating on/off bursts. Bursts are either a fixed count or continuous. The controller uses it for pedestrian-crossing chirps and fault alarms. A start/stop handshake with busy/done status replaces the fixed free-running 25 Hz beeper.

## Interface
- DIV_W, 20: width of tone period counter.
- GATE_W, 25: width of burst on/off time counters (25 bits, about 1.34 s at 25 MHz).
- REP_W, 8: width of repetition count.
- ext_clk_25m  in  1  25 MHz system clock; all logic on rising edge.
- ext_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  abort; sampled in every state.
- period  in  DIV_W  tone period in clocks; values below 2 are clamped to 2.
- duty  in  8  high fraction = duty/256 of period.
- on_time  in  GATE_W  burst on length in clocks; 0 is treated as 1.
- off_time  in  GATE_W  burst off length in clocks; 0 skips the OFF phase.
- reps  in  REP_W  number of bursts; 0 means infinite until stop.
- beep  out  1  buzzer drive, registered.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE: beep=0, counters cleared.
  - LOAD: one cycle; computes high_cnt.
  - ON: tone active.
  - OFF: silent.
- IDLE→LOAD on start:
  - latches period (clamped), duty, on_time (clamped), off_time and reps into internal registers;
  - busy<=1.
  - Inputs are ignored after the latch.
- LOAD→ON:
  - high_cnt <= (period_r × duty_r) >> 8, with a full DIV_W+8-bit product truncated back to DIV_W;
  - tcnt<=0, gcnt<=0, rcnt<=0.
- ON:
  - tcnt counts 0..period_r−1 and wraps to 0;
  - beep <= (tcnt < high_cnt); duty=0 gives silence;
  - gcnt counts 0..on_time_r−1; at gcnt==on_time_r−1 the next edge leaves ON with gcnt<=0.
- Leaving ON:
  - goes to OFF if off_time_r≠0;
  - otherwise counts the burst end directly (see end of burst).
- OFF: beep<=0; gcnt counts 0..off_time_r−1, then the burst ends.
- End of burst:
  - rcnt<=rcnt+1;
  - if reps_r≠0 and rcnt+1==reps_r: →IDLE, done<=1 for one cycle, busy<=0;
  - else →ON with tcnt<=0, so every burst starts on a rising tone edge.
- rcnt saturates at its maximum when reps_r=0; it never wraps to a false completion.
- stop in any non-IDLE state:
  - →IDLE on the next edge; beep<=0, busy<=0;
  - no done pulse.
- start and stop in the same cycle: stop wins and start is discarded.
- start while busy: ignored. No queueing.
- Reset values: state=IDLE, beep=0, busy=0, done=0, all counters 0.

## Timing
- start sampled at edge k:
  - busy=1 after edge k;
  - state=ON after edge k+1;
  - first beep=1 after edge k+2 (when high_cnt>0).
- beep lags the state/counter decode by exactly one clock.
- Burst cycle is on_time_r + off_time_r clocks.
- With finite reps, IDLE, done=1 and busy=0 all occur after edge k+1+reps_r×(on_time_r+off_time_r). done clears on the following edge.
- stop at edge s: beep=0 and busy=0 after edge s.
- Asynchronous reset mid-burst forces all outputs to their reset values immediately. Outputs are released at the first clock edge after deassertion.

## Configuration
- BEEP_ACTIVE_LOW_EN:
  - defined: the beep pin is inverted for a PNP-driven buzzer. Reset value, IDLE and OFF levels are 1; a tone high is 0.
  - undefined: beep is active-high as described above.
- busy and done are unaffected by the macro.

## Test plan
- Tone shape: period=10, duty=128, on_time=40, off_time=20, reps=3, start at edge k → each burst is 4 cycles of 5 high/5 low; 20 low between bursts; done pulse and busy fall after edge k+181.
- Clamping: period=1, duty=128, on_time=0, off_time=0, reps=2 → period 2, 1 high/1 low, burst length 1 clock; done after edge k+3.
- Silence and full duty: duty=0 → beep stays 0 while busy=1. duty=255 with period=256 → 255 high/1 low.
- Infinite bursts and stop: reps=0 runs more than 300 bursts without a done pulse; stop mid-ON → beep=0 and busy=0 on the next edge, no done pulse.
- Handshake edge cases:
  - start while busy is ignored and the burst count is unchanged;
  - start+stop in the same cycle from IDLE → stays IDLE;
  - input changes after the latch have no effect.
- Reset mid-OFF, then a new start → the full sequence runs from rcnt=0. Repeat with BEEP_ACTIVE_LOW_EN defined → beep is the inverse and idles at 1.
